// File: rtl/pwm_fade_ctrl.sv
// Per-channel fade controller: ramps each channel's working level one LSB per
// prescaler tick toward its target and commits it to the PWM bank at period starts.
module pwm_fade_ctrl #(
   parameter int WIDTH      = 8,
   parameter int CHANNELS   = 3,
   parameter int PRESCALE_W = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [PRESCALE_W-1:0]        rate,
   input  logic [CHANNELS*WIDTH-1:0]    target,
   input  logic [CHANNELS-1:0]          load,
   input  logic                         period_start,
   output logic [CHANNELS*WIDTH-1:0]    level,
   output logic [CHANNELS-1:0]          busy,
   output logic [CHANNELS-1:0]          done
);

   // state    | meaning
   // S_IDLE   | level settled on target; ticks ignored
   // S_FADING | work steps toward tgt; finishes once work and level both equal tgt
   typedef enum logic {
      S_IDLE   = 1'b0,
      S_FADING = 1'b1
   } state_t;

   logic [PRESCALE_W-1:0] count_q;
   logic                  tick;
   logic [WIDTH-1:0]      tgt_q   [CHANNELS];
   logic [WIDTH-1:0]      work_q  [CHANNELS];
   state_t                state_q [CHANNELS];

   // >= rather than == so lowering rate below the current count cannot run away
   assign tick = (count_q >= rate);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
         level   <= '0;
         busy    <= '0;
         done    <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            tgt_q[i]   <= '0;
            work_q[i]  <= '0;
            state_q[i] <= S_IDLE;
         end
      end else begin
         count_q <= tick ? '0 : count_q + PRESCALE_W'(1);
         for (int i = 0; i < CHANNELS; i++) begin
            done[i] <= 1'b0;
            if (period_start)
               level[i*WIDTH +: WIDTH] <= work_q[i];
            if (load[i]) begin
               // a load cycle never steps work, even when a tick coincides
               tgt_q[i]   <= target[i*WIDTH +: WIDTH];
               state_q[i] <= S_FADING;
               busy[i]    <= 1'b1;
            end else if (state_q[i] == S_FADING) begin
               if ((work_q[i] == tgt_q[i]) && (level[i*WIDTH +: WIDTH] == tgt_q[i])) begin
                  state_q[i] <= S_IDLE;
                  busy[i]    <= 1'b0;
                  done[i]    <= 1'b1;
               end else if (tick) begin
                  if (work_q[i] < tgt_q[i])
                     work_q[i] <= work_q[i] + WIDTH'(1);
                  else if (work_q[i] > tgt_q[i])
                     work_q[i] <= work_q[i] - WIDTH'(1);
               end
            end
         end
      end
   end

endmodule

// File: doc/pwm_fade_ctrl.md
Name: pwm_fade_ctrl

Overview:
Per-channel fade controller that sequences the duty levels feeding a bank of PWM generators, such as the R/G/B channels of the mixer. On a load strobe, each channel ramps its working level one LSB at a time toward a new target. The step rate comes from a shared programmable prescaler. Levels are presented to the PWM generators only at PWM period boundaries, so duty never changes mid-period.

Parameters:
WIDTH, 8, bits per channel level; matches the PWM generator WIDTH
CHANNELS, 3, number of independent fade channels
PRESCALE_W, 16, width of the step-rate prescaler

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous reset, active-low
rate  input  PRESCALE_W  step interval: one step tick every rate+1 cycles
target  input  CHANNELS*WIDTH  per-channel target level; channel i occupies bits [i*WIDTH +: WIDTH]
load  input  CHANNELS  per-channel strobe that captures target[i]
period_start  input  1  one-cycle pulse at a PWM period boundary (PWM counter == 0)
level  output  CHANNELS*WIDTH  per-channel committed duty level, drives the PWM generators
busy  output  CHANNELS  channel i is fading
done  output  CHANNELS  one-cycle pulse when channel i finishes a fade

Behaviour:
- Reset: all of the following are cleared on a clk edge with rst_n=0:
  - prescaler count = 0
  - per channel: tgt = 0, work = 0, state = IDLE
  - outputs: level = 0, busy = 0, done = 0
- Reset mid-fade: everything is zero on the next edge, and no done pulse is generated.
- Prescaler:
  - Free-running; tick = (count >= rate).
  - On tick, count <= 0; otherwise count <= count + 1.
  - rate = 0 gives a tick every cycle.
  - rate may change at any time; the >= compare prevents runaway when count > new rate.
  - The prescaler runs regardless of channel state.
- Channel FSM, two states, IDLE and FADING; busy[i] = (state == FADING), registered.
- Load (any state, highest priority):
  - load[i] at cycle n: tgt <= target[i] and state <= FADING, both visible at n+1.
  - No step is applied to work in a cycle where load[i] is high, even if tick is high.
- Step, in FADING, tick=1, no load:
  - work < tgt: work <= work + 1.
  - work > tgt: work <= work - 1.
  - work == tgt: work unchanged.
  - work never crosses tgt and never wraps; arithmetic is WIDTH bits, unsigned.
- Commit: period_start=1 at cycle p makes level[i] = work[i] (value at p) visible at p+1.
  - All channels commit simultaneously.
  - Between period_start pulses, level holds.
- Completion:
  - Condition: state == FADING, work == tgt, level == tgt, and load[i]=0 in the same cycle.
  - Result on the next edge: state <= IDLE, busy[i] <= 0, done[i] <= 1 for exactly one cycle.
- Load in IDLE with target equal to current level and work:
  - Enters FADING, then completes one cycle later.
  - busy is high for 1 cycle, then a done pulse.
- Retarget mid-fade: work steps from its current value toward the new tgt, with no reset to 0.
  - Equality of level with the new tgt alone does not complete; work must also match.
- Ticks in IDLE are ignored; work and level are stable.
- Channels are fully independent except for the shared prescaler and period_start.
- Latency from load to first level change: 1 cycle (load), then the first tick, then the next period_start, plus 1.

Test Plan:
- Reset: hold rst_n=0 with load=3'b111 and target=FF/FF/FF -> level=0, busy=0, done=0 throughout. Release: outputs stay 0 with load idle.
- Up-fade: rate=0, period_start every 4 cycles, load[0] with target=5 -> work[0] steps 1..5 on consecutive cycles; level[0] takes the work value at each period_start (+1 cycle) until it reaches 5; then done[0] pulses once, busy[0] falls, level[1], level[2] stay 0.
- Down-fade with prescale: from level 5, rate=3, load[0] target=2 -> work[0] decrements once every 4 cycles (4,3,2); no step on the load cycle; done[0] pulses after level[0]==2 commits.
- Retarget and collision:
  - Mid-fade 0->200 with work=100, load target=80 on a tick cycle -> no step that cycle; work then decrements 100->80; no done before work==80 and level==80.
  - Simultaneous load on two channels -> both proceed independently.
- Commit gating: period_start held 0 for 50 cycles while work reaches target=10 -> level frozen, busy stays 1, no done. Then one period_start pulse -> level=10 next cycle, done pulse the cycle after completion is detected.
- Reset mid-fade: rst_n=0 for one cycle while busy=3'b111 -> next cycle level=0, busy=0, done=0. A subsequent load behaves as from power-up.
